// File: rtl/axi4s_lfsr_descrambler.sv
// axi4s_lfsr_descrambler: frame-synchronous additive LFSR descrambler on AXI4-Stream with a two-entry skid buffer.
// Define AXI4S_LFSR_DESCR_STATS_EN to implement frame_count/resync_count; otherwise both ports read 0.
// Keystream: per beat, TDATA_WIDTH Fibonacci steps; bit i of the keystream is the feedback bit of step i
// (fb = ^(state & POLYNOMIAL), state <= {state[D-2:0], fb}), matching the transmit-side axi4s_lfsr.
module axi4s_lfsr_descrambler #(
   parameter int                     POLY_DEGREE = 16,
   parameter logic [POLY_DEGREE-1:0] POLYNOMIAL  = 16'b0110100000000001,
   parameter logic [POLY_DEGREE-1:0] SEED        = 1,
   parameter int                     TDATA_WIDTH = 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   resync,
   input  logic                   target_tvalid,
   output logic                   target_tready,
   input  logic [TDATA_WIDTH-1:0] target_tdata,
   input  logic                   target_tlast,
   output logic                   initiator_tvalid,
   input  logic                   initiator_tready,
   output logic [TDATA_WIDTH-1:0] initiator_tdata,
   output logic                   initiator_tlast,
   output logic [31:0]            frame_count,
   output logic [15:0]            resync_count
);

   function automatic logic [POLY_DEGREE+TDATA_WIDTH-1:0] lfsr_step(input logic [POLY_DEGREE-1:0] s_in);
      logic [POLY_DEGREE-1:0] s;
      logic [TDATA_WIDTH-1:0] k;
      logic                   fb;
      s = s_in;
      k = '0;
      for (int i = 0; i < TDATA_WIDTH; i++) begin
         fb   = ^(s & POLYNOMIAL);
         k[i] = fb;
         s    = {s[POLY_DEGREE-2:0], fb};
      end
      return {s, k};
   endfunction

   logic [POLY_DEGREE-1:0] lfsr_state, cur_state, nxt_state;
   logic [TDATA_WIDTH-1:0] keystream, plain, skid_data;
   logic                   skid_valid, skid_last, in_frame, pending;
   logic                   accept, pop, apply_resync;
   logic                   out_load_new, skid_load, out_valid_n, skid_valid_n;

   // Outside a frame the keystream always starts from SEED, so a pending resync costs nothing extra.
   assign cur_state              = in_frame ? lfsr_state : SEED;
   assign {nxt_state, keystream} = lfsr_step(cur_state);
   assign plain                  = target_tdata ^ keystream;
   assign accept                 = target_tvalid && target_tready;
   assign pop                    = initiator_tvalid && initiator_tready;
   assign apply_resync           = (resync || pending) && (!in_frame || (accept && target_tlast));

   // Skid buffer next-state: skid only holds data when full, and no accept can happen while full.
   always_comb begin
      out_load_new = accept && (!initiator_tvalid || pop);
      skid_load    = accept && initiator_tvalid && !pop;
      out_valid_n  = skid_valid || accept || (initiator_tvalid && !pop);
      skid_valid_n = skid_valid ? !pop : skid_load;
   end

   // Output register, skid entry and registered ready (low exactly while both entries are occupied).
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         initiator_tvalid <= 1'b0;
         initiator_tdata  <= '0;
         initiator_tlast  <= 1'b0;
         skid_valid       <= 1'b0;
         skid_data        <= '0;
         skid_last        <= 1'b0;
         target_tready    <= 1'b0;
      end else begin
         initiator_tvalid <= out_valid_n;
         skid_valid       <= skid_valid_n;
         target_tready    <= !(out_valid_n && skid_valid_n);
         if (skid_valid && pop) {initiator_tdata, initiator_tlast} <= {skid_data, skid_last};
         else if (out_load_new) {initiator_tdata, initiator_tlast} <= {plain, target_tlast};
         if (skid_load) {skid_data, skid_last} <= {plain, target_tlast};
      end
   end

   // Keystream state, frame tracking and deferred resync request.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lfsr_state <= SEED;
         in_frame   <= 1'b0;
         pending    <= 1'b0;
      end else begin
         if (accept) begin
            lfsr_state <= target_tlast ? SEED : nxt_state;
            in_frame   <= !target_tlast;
         end
         pending <= (pending || resync) && !apply_resync;
      end
   end

`ifdef AXI4S_LFSR_DESCR_STATS_EN
   logic [31:0] frames;
   logic [15:0] resyncs;

   // Frames count on tlast acceptance (wrapping); applied resyncs saturate.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         frames  <= '0;
         resyncs <= '0;
      end else begin
         frames  <= frames + 32'(accept && target_tlast);
         resyncs <= (apply_resync && resyncs != '1) ? resyncs + 16'd1 : resyncs;
      end
   end

   assign frame_count  = frames;
   assign resync_count = resyncs;
`else
   assign frame_count  = '0;
   assign resync_count = '0;
`endif

endmodule

// File: tb/tb_axi4s_lfsr_descrambler.sv
// tb_axi4s_lfsr_descrambler: directed bench for the AXI4-Stream LFSR descrambler.
module tb_axi4s_lfsr_descrambler;

   localparam logic [15:0] POLY = 16'b0110100000000001;
`ifdef AXI4S_LFSR_DESCR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        aclk = 1'b0, aresetn = 1'b0, resync = 1'b0;
   logic        target_tvalid = 1'b0, target_tlast = 1'b0, initiator_tready = 1'b1;
   logic [7:0]  target_tdata = 8'h00;
   logic        target_tready, initiator_tvalid, initiator_tlast;
   logic [7:0]  initiator_tdata;
   logic [31:0] frame_count;
   logic [15:0] resync_count;

   always #5 aclk = ~aclk;

   axi4s_lfsr_descrambler dut (
      .aclk(aclk), .aresetn(aresetn), .resync(resync),
      .target_tvalid(target_tvalid), .target_tready(target_tready),
      .target_tdata(target_tdata), .target_tlast(target_tlast),
      .initiator_tvalid(initiator_tvalid), .initiator_tready(initiator_tready),
      .initiator_tdata(initiator_tdata), .initiator_tlast(initiator_tlast),
      .frame_count(frame_count), .resync_count(resync_count)
   );

   int         checks = 0, errors = 0;
   int         n_acc = 0, n_emit = 0;
   bit         mon_en = 1'b0, rnd = 1'b0;
   logic [7:0] ks[64];
   logic [8:0] out_q[$], exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshakes are sampled mid-cycle; they take effect on the following rising edge.
   always @(negedge aclk) begin
      if (!aresetn) begin
         n_acc  = 0;
         n_emit = 0;
      end else begin
         if (mon_en) begin
            chk("tready_vs_held", {31'b0, target_tready}, {31'b0, (n_acc - n_emit) < 2});
            chk("tvalid_vs_held", {31'b0, initiator_tvalid}, {31'b0, (n_acc - n_emit) > 0});
         end
         if (target_tvalid && target_tready) n_acc++;
         if (initiator_tvalid && initiator_tready) begin
            n_emit++;
            out_q.push_back({initiator_tlast, initiator_tdata});
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      int t;
      t = 0;
      target_tvalid = 1'b1;
      target_tdata  = d;
      target_tlast  = l;
      @(negedge aclk);
      while (!target_tready && t < 100) begin
         @(posedge aclk); #1;
         if (rnd) initiator_tready = 1'($urandom_range(0, 1));
         @(negedge aclk);
         t++;
      end
      chk("send_accept", {31'b0, target_tready}, 32'd1);
      @(posedge aclk); #1;
      if (rnd) initiator_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic beat(input int j, input logic [7:0] d, input logic l);
      send(d ^ ks[j], l);
      exp_q.push_back({l, d});
   endtask

   task automatic frame(input int n, input int base);
      for (int j = 0; j < n; j++) beat(j, 8'(base + j), j == n - 1);
      target_tvalid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      target_tvalid = 1'b0;
      while (out_q.size() < exp_q.size() && t < 500) begin
         @(posedge aclk); #1;
         if (rnd) initiator_tready = 1'($urandom_range(0, 1));
         t++;
      end
      rnd = 1'b0;
      initiator_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk({tag, "_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk(tag, (i < out_q.size()) ? {23'b0, out_q[i]} : 32'hFFFF_FFFF, {23'b0, exp_q[i]});
      out_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] s;
      logic        fb;
      longint      t0;
      s = 16'd1;
      for (int n = 0; n < 64; n++)
         for (int b = 0; b < 8; b++) begin
            fb       = ^(s & POLY);
            ks[n][b] = fb;
            s        = {s[14:0], fb};
         end

      // reset values
      #12;
      chk("rst_tvalid", {31'b0, initiator_tvalid}, 0);
      chk("rst_tdata", {24'b0, initiator_tdata}, 0);
      chk("rst_tlast", {31'b0, initiator_tlast}, 0);
      chk("rst_tready", {31'b0, target_tready}, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_resync_count", {16'b0, resync_count}, 0);
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("tready_after_reset", {31'b0, target_tready}, 1);
      mon_en = 1'b1;

      // loopback: two 16-beat frames of 0x00..0x0F, back to back
      t0 = $time;
      for (int f = 0; f < 2; f++)
         for (int j = 0; j < 16; j++) begin
            beat(j, 8'(j), j == 15);
            if (f == 0 && j == 0)
               chk("latency", {22'b0, initiator_tvalid, initiator_tlast, initiator_tdata}, {22'b0, 1'b1, 1'b0, 8'h00});
         end
      chk("throughput_cycles", 32'(($time - t0) / 10), 32);
      target_tvalid = 1'b0;
      chk("fc_loopback", frame_count, STATS ? 2 : 0);
      drain("loopback");

      // hand-computed keystream: first two bytes from SEED=1 are 0xFF, 0xB7
      send(8'hFF, 1'b0);
      exp_q.push_back({1'b0, 8'h00});
      send(8'hB7, 1'b1);
      exp_q.push_back({1'b1, 8'h00});
      target_tvalid = 1'b0;
      drain("hand_vector");

      // backpressure: 64 beats as four frames with random downstream ready
      rnd = 1'b1;
      for (int f = 0; f < 4; f++) frame(16, 8'h40 + 16 * f);
      drain("backpressure");
      chk("fc_backpressure", frame_count, STATS ? 7 : 0);

      // single-beat frames
      for (int i = 0; i < 8; i++) beat(0, 8'(i * 37 + 5), 1'b1);
      target_tvalid = 1'b0;
      drain("single_beat");
      chk("fc_single", frame_count, STATS ? 15 : 0);

      // resync mid-frame, then a new frame from SEED
      for (int j = 0; j < 10; j++) begin
         resync = (j == 4);
         beat(j, 8'(8'hA0 + j), j == 9);
      end
      resync = 1'b0;
      frame(6, 8'h20);
      drain("resync_mid");
      chk("rc_mid", {16'b0, resync_count}, STATS ? 1 : 0);

      // resync coincident with tlast, then a second resync while idle
      for (int j = 0; j < 3; j++) begin
         resync = (j == 2);
         beat(j, 8'(8'h70 + j), j == 2);
      end
      resync = 1'b0;
      target_tvalid = 1'b0;
      chk("rc_coincident", {16'b0, resync_count}, STATS ? 2 : 0);
      resync = 1'b1;
      @(posedge aclk); #1;
      resync = 1'b0;
      frame(4, 8'h90);
      drain("resync_coincident");
      chk("rc_total", {16'b0, resync_count}, STATS ? 3 : 0);
      chk("fc_resync", frame_count, STATS ? 19 : 0);

      // reset mid-frame with two beats buffered
      for (int j = 0; j < 5; j++) begin
         send(8'(j) ^ ks[j], 1'b0);
         if (j < 4) exp_q.push_back({1'b0, 8'(j)});
      end
      initiator_tready = 1'b0;
      send(8'd5 ^ ks[5], 1'b0);
      target_tvalid = 1'b0;
      @(negedge aclk);
      chk("full_tready", {31'b0, target_tready}, 0);
      #2;
      mon_en  = 1'b0;
      aresetn = 1'b0;
      #1;
      chk("async_rst_tvalid", {31'b0, initiator_tvalid}, 0);
      chk("async_rst_tready", {31'b0, target_tready}, 0);
      chk("async_rst_tdata", {24'b0, initiator_tdata}, 0);
      chk("async_rst_fc", frame_count, 0);
      chk("async_rst_rc", {16'b0, resync_count}, 0);
      drain("pre_reset");
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk); #1;
      mon_en = 1'b1;
      chk("post_rst_fc", frame_count, 0);
      chk("post_rst_rc", {16'b0, resync_count}, 0);
      frame(8, 8'h10);
      drain("post_reset");
      chk("fc_post_reset", frame_count, STATS ? 1 : 0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
